// File: rtl/instr_fetch_if.sv
// Program-memory bus between the fetch unit and a fixed-latency responder.
// The consumer issues single-cycle read pulses; the responder answers exactly
// two cycles later with no backpressure.
interface program_memory_bus;
  logic [31:0] addr;
  logic        read_request;
  logic [31:0] instr;
  logic        data_valid;

  modport CONSUMER (
    output addr,
    output read_request,
    input  instr,
    input  data_valid
  );

  modport RESPONDER (
    input  addr,
    input  read_request,
    output instr,
    output data_valid
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues sequential word reads to a fixed-latency
// program memory, buffers returned words with their pcs in a small FIFO and
// hands them downstream over a valid/ready port. Redirects flush the buffer
// and drain any words still in flight before fetching from the new pc.
// Optional macro IFETCH_DELIVERED_COUNT_EN adds a delivered-instruction counter.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  program_memory_bus.CONSUMER      bus,
  input  logic                     redirect_in,
  input  logic [31:0]              redirect_pc_in,
  output logic [31:0]              instr_out,
  output logic [31:0]              pc_out,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic [31:0]              delivered_count_out
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthW = (CntW + 1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {StFetch, StDrain} state_e;

  state_e            r_state, w_state_d;
  logic [31:0]       r_fetch_pc;
  logic [31:0]       r_tag_pc;
  logic [CntW-1:0]   r_inflight, w_inflight_d;
  logic [CntW-1:0]   r_count;
  logic [PtrW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [1:0]        r_drop;
  logic [31:0]       r_mem_instr [FIFO_DEPTH];
  logic [31:0]       r_mem_pc    [FIFO_DEPTH];

  logic        w_rsp, w_issue, w_push, w_pop, w_valid;
  logic [31:0] w_redirect_pc;
  logic        w_unused_pc_lsb;

  assign w_redirect_pc   = {redirect_pc_in[31:2], 2'b00};
  assign w_unused_pc_lsb = ^redirect_pc_in[1:0];

  // Returns from requests issued before a reset land inside the drop window.
  assign w_rsp = bus.data_valid && (r_drop == 2'd0);

  // Next-state, issue, buffer handshake and inflight bookkeeping.
  always_comb begin
    w_state_d    = r_state;
    w_issue      = 1'b0;
    w_push       = 1'b0;
    w_valid      = 1'b0;
    w_pop        = 1'b0;
    w_inflight_d = r_inflight;

    if (rst_in && !redirect_in && r_state == StFetch) begin
      // Reserving space for inflight words means a return never finds the FIFO full.
      w_issue = ({1'b0, r_count} + {1'b0, r_inflight}) < DepthW;
      w_push  = w_rsp;
      w_valid = r_count != '0;
      w_pop   = w_valid && ready_in;
    end

    w_inflight_d = r_inflight + CntW'(w_issue) - CntW'(w_rsp);

    if (redirect_in) begin
      w_state_d = (w_inflight_d != '0) ? StDrain : StFetch;
    end else if (r_state == StDrain && w_inflight_d == '0) begin
      w_state_d = StFetch;
    end
  end

  // Control state, fetch/tag pcs and FIFO pointers.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state    <= StFetch;
      r_fetch_pc <= RESET_PC;
      r_tag_pc   <= RESET_PC;
      r_inflight <= '0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_drop     <= 2'd2;
    end else begin
      r_state    <= w_state_d;
      r_inflight <= w_inflight_d;
      r_drop     <= (r_drop != 2'd0) ? r_drop - 2'd1 : 2'd0;
      if (redirect_in) begin
        r_fetch_pc <= w_redirect_pc;
        r_tag_pc   <= w_redirect_pc;
        r_count    <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
      end else begin
        if (w_issue) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_push) begin
          r_tag_pc <= r_tag_pc + 32'd4;
          r_wr_ptr <= r_wr_ptr + PtrW'(1);
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + PtrW'(1);
        r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
      end
    end
  end

  // FIFO storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk_in) begin
    if (rst_in && w_push) begin
      r_mem_instr[r_wr_ptr] <= bus.instr;
      r_mem_pc[r_wr_ptr]    <= r_tag_pc;
    end
  end

  assign bus.read_request = w_issue;
  assign bus.addr         = rst_in ? r_fetch_pc : RESET_PC;
  assign valid_out        = w_valid;
  assign instr_out        = rst_in ? r_mem_instr[r_rd_ptr] : 32'd0;
  assign pc_out           = rst_in ? r_mem_pc[r_rd_ptr] : 32'd0;

`ifdef IFETCH_DELIVERED_COUNT_EN
  logic [31:0] r_delivered;

  // Count accepted transfers; a redirect suppresses the pop and thus the count.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_delivered <= 32'd0;
    end else if (w_pop) begin
      r_delivered <= r_delivered + 32'd1;
    end
  end

  assign delivered_count_out = rst_in ? r_delivered : 32'd0;
`else
  assign delivered_count_out = 32'd0;
`endif

endmodule
